// File: rtl/hazard_sched_pkg.sv
// -----------------------------------------------------------------------------
// hazard_sched_pkg
// Shared definitions for the five-stage MIPS hazard controller:
//   - opcode / funct encodings of the supported instruction subset
//   - bypass-select encodings driven onto the datapath operand muxes
//   - width of the Tuse/Tnew timing values and the "source not read" marker
//   - reg_hit(): register-match helper that never matches $0
// -----------------------------------------------------------------------------
package hazard_sched_pkg;

  // Primary opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct codes
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;

  // Operand bypass selects
  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_E    = 2'b01,
    FWD_M    = 2'b10,
    FWD_W    = 2'b11
  } fwd_sel_e;

  // Tuse / Tnew values (0..2 are real timings)
  localparam int T_W = 2;
  typedef logic [T_W-1:0] t_val_t;

  // Larger than any Tnew, so an unread source can never compare as a hazard
  localparam t_val_t TUSE_UNUSED = 2'd3;

  localparam logic [4:0] REG_RA = 5'd31;

  // True when src is a real register ($1..$31) and equals dest
  function automatic logic reg_hit(input logic [4:0] src, input logic [4:0] dest);
    return (src != '0) && (src == dest);
  endfunction

endpackage

// File: rtl/hazard_sched_class.sv
// -----------------------------------------------------------------------------
// hz_class
// Combinational classifier for the instruction sitting in D.
//   valid, op, func, rs, rt, rd : D-stage instruction fields
//   dest                        : destination register (0 = none)
//   tnew                        : cycles after entering E until the result exists
//   tuse_rs / tuse_rt           : cycles from D until the operand is consumed
//   use_rs / use_rt             : operand is actually read
// Unknown encodings and valid=0 classify as a nop.
// -----------------------------------------------------------------------------
module hz_class
  import hazard_sched_pkg::*;
(
  input  logic       valid,
  input  logic [5:0] op,
  input  logic [5:0] func,
  input  logic [4:0] rs,
  input  logic [4:0] rt,
  input  logic [4:0] rd,
  output logic [4:0] dest,
  output t_val_t     tnew,
  output t_val_t     tuse_rs,
  output t_val_t     tuse_rt,
  output logic       use_rs,
  output logic       use_rt
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves
    // a value unassigned -- that is what keeps this from inferring latches.
    dest    = '0;
    tnew    = '0;
    tuse_rs = TUSE_UNUSED;
    tuse_rt = TUSE_UNUSED;
    if (valid) begin
      case (op)
        OP_RTYPE: begin
          case (func)
            FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR, FN_XOR: begin
              dest    = rd;
              tnew    = 2'd1;
              tuse_rs = 2'd1;
              tuse_rt = 2'd1;
            end
            FN_SLL, FN_SRL: begin
              dest    = rd;
              tnew    = 2'd1;
              tuse_rt = 2'd1;
            end
            FN_JR: tuse_rs = 2'd0;
            default: ;
          endcase
        end
        OP_ORI, OP_LUI, OP_ADDI, OP_ADDIU: begin
          dest    = rt;
          tnew    = 2'd1;
          tuse_rs = 2'd1;
        end
        OP_LW: begin
          dest    = rt;
          tnew    = 2'd2;
          tuse_rs = 2'd1;
        end
        OP_SW: begin
          tuse_rs = 2'd1;
          tuse_rt = 2'd2;
        end
        OP_BEQ, OP_BNE: begin
          tuse_rs = 2'd0;
          tuse_rt = 2'd0;
        end
        OP_JAL:  dest = REG_RA;
        default: ;
      endcase
    end
  end

  assign use_rs = (tuse_rs != TUSE_UNUSED);
  assign use_rt = (tuse_rt != TUSE_UNUSED);

endmodule

// File: rtl/hazard_sched.sv
// -----------------------------------------------------------------------------
// hazard_sched
// Stall and forwarding controller for a five-stage F/D/E/M/W MIPS pipeline.
// Keeps a shadow of destination registers and remaining Tnew for E/M/W and
// derives the D stall plus the bypass selects for D, E and M operands.
//   clk, reset                 : clock, synchronous active-high reset
//   d_valid, d_op, d_func,
//   d_rs, d_rt, d_rd           : D-stage instruction fields
//   stall                      : freeze F/D, inject a bubble into E
//   fwd_d_rs/rt                : D bypass (00 regfile, 01 E, 10 M, 11 W)
//   fwd_e_rs/rt                : E bypass (00 pipe, 10 M, 11 W)
//   fwd_m_rt                   : M store-data bypass (00 pipe, 11 W)
//   e_dest, m_dest, w_dest     : shadow destinations (debug)
//   stall_cnt                  : saturating stall-cycle counter
// -----------------------------------------------------------------------------
module hazard_sched
  import hazard_sched_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             d_valid,
  input  logic [5:0]       d_op,
  input  logic [5:0]       d_func,
  input  logic [4:0]       d_rs,
  input  logic [4:0]       d_rt,
  input  logic [4:0]       d_rd,
  output logic             stall,
  output logic [1:0]       fwd_d_rs,
  output logic [1:0]       fwd_d_rt,
  output logic [1:0]       fwd_e_rs,
  output logic [1:0]       fwd_e_rt,
  output logic [1:0]       fwd_m_rt,
  output logic [4:0]       e_dest,
  output logic [4:0]       m_dest,
  output logic [4:0]       w_dest,
  output logic [CNT_W-1:0] stall_cnt
);

  logic [4:0] d_dest;
  t_val_t     d_tnew, d_tuse_rs, d_tuse_rt;
  logic       d_use_rs, d_use_rt;

  hz_class u_class (
    .valid   (d_valid),
    .op      (d_op),
    .func    (d_func),
    .rs      (d_rs),
    .rt      (d_rt),
    .rd      (d_rd),
    .dest    (d_dest),
    .tnew    (d_tnew),
    .tuse_rs (d_tuse_rs),
    .tuse_rt (d_tuse_rt),
    .use_rs  (d_use_rs),
    .use_rt  (d_use_rt)
  );

  // Unread sources collapse to $0 so they can never match or forward
  logic [4:0] d_src_rs, d_src_rt;
  assign d_src_rs = d_use_rs ? d_rs : 5'd0;
  assign d_src_rt = d_use_rt ? d_rt : 5'd0;

  // Shadow state: e_tnew/m_tnew hold the cycles still needed in that stage;
  // W never needs a counter because every result exists by then.
  t_val_t     e_tnew, m_tnew;
  logic [4:0] e_rs, e_rt, m_rt;

  // Nearest producer wins; a producer still computing gives 00 and the
  // operand is repaired by a later-stage bypass.
  function automatic fwd_sel_e nearest_src(
    input logic [4:0] src,
    input logic [4:0] ed,
    input logic [4:0] md,
    input logic [4:0] wd,
    input t_val_t     et,
    input t_val_t     mt
  );
    fwd_sel_e sel;
    sel = FWD_NONE;
    if (reg_hit(src, ed)) begin
      if (et == '0) sel = FWD_E;
    end else if (reg_hit(src, md)) begin
      if (mt == '0) sel = FWD_M;
    end else if (reg_hit(src, wd)) begin
      sel = FWD_W;
    end
    return sel;
  endfunction

  logic stall_rs, stall_rt;
  assign stall_rs = (reg_hit(d_src_rs, e_dest) && (d_tuse_rs < e_tnew)) ||
                    (reg_hit(d_src_rs, m_dest) && (d_tuse_rs < m_tnew));
  assign stall_rt = (reg_hit(d_src_rt, e_dest) && (d_tuse_rt < e_tnew)) ||
                    (reg_hit(d_src_rt, m_dest) && (d_tuse_rt < m_tnew));
  assign stall    = stall_rs || stall_rt;

  // Downstream paths reuse the same rule with the nearer stages masked off
  assign fwd_d_rs = nearest_src(d_src_rs, e_dest, m_dest, w_dest, e_tnew, m_tnew);
  assign fwd_d_rt = nearest_src(d_src_rt, e_dest, m_dest, w_dest, e_tnew, m_tnew);
  assign fwd_e_rs = nearest_src(e_rs, 5'd0, m_dest, w_dest, '0, m_tnew);
  assign fwd_e_rt = nearest_src(e_rt, 5'd0, m_dest, w_dest, '0, m_tnew);
  assign fwd_m_rt = nearest_src(m_rt, 5'd0, 5'd0, w_dest, '0, '0);

  always_ff @(posedge clk) begin
    // NOTE: the shadow is a handful of flops, not a memory, so all of it is
    // cleared here; a reset coinciding with a stall simply empties the pipe.
    if (reset) begin
      e_dest    <= '0;
      e_tnew    <= '0;
      e_rs      <= '0;
      e_rt      <= '0;
      m_dest    <= '0;
      m_tnew    <= '0;
      m_rt      <= '0;
      w_dest    <= '0;
      stall_cnt <= '0;
    end else begin
      // NOTE: non-blocking assignments let M and W sample the pre-edge E/M
      // values, so the shift below is order-independent.
      if (stall) begin
        e_dest <= '0;
        e_tnew <= '0;
        e_rs   <= '0;
        e_rt   <= '0;
      end else begin
        e_dest <= d_dest;
        e_tnew <= d_tnew;
        e_rs   <= d_src_rs;
        e_rt   <= d_src_rt;
      end
      m_dest <= e_dest;
      m_tnew <= (e_tnew == '0) ? '0 : e_tnew - t_val_t'(1);
      m_rt   <= e_rt;
      w_dest <= m_dest;
      if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule
